ub_read_sequencer: RTL and testbench

// Address generator and read-return buffer on unified_buffer port 0 (address0/en0 -> read_port0).

---
 rtl/ub_read_sequencer_pkg.sv | 19 +
 rtl/ub_read_sequencer_return_fifo.sv | 54 +++++
 rtl/ub_read_sequencer.sv | 145 ++++++++++++++
 tb/tb_ub_read_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ub_read_sequencer_pkg.sv
// Shared types for the unified-buffer read sequencer.
// Byte/address types, read latency and sequencer FSM states.
package ub_read_sequencer_pkg;

  typedef logic [7:0] BYTE_TYPE;

  localparam int UB_TILE_WIDTH = 4096;
  localparam int UB_READ_LATENCY = 3;

  typedef logic [$clog2(UB_TILE_WIDTH)-1:0] BUFFER_ADDRESS_TYPE;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ub_rd_state_t;

endpackage

// File: rtl/ub_read_sequencer_return_fifo.sv
// Show-ahead return FIFO holding {last, row bytes}.
// Caller guarantees no push when full (credit scheme upstream).
module ub_return_fifo #(
  parameter int W = 113,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop && (count_q != '0);
    wptr_d  = push ? bump(wptr_q) : wptr_q;
    rptr_d  = do_pop ? bump(rptr_q) : rptr_q;
    count_d = count_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/ub_read_sequencer.sv
// Issues strided row reads on unified_buffer port 0 and streams
// the returned rows out through a credit-protected FIFO.
module ub_read_sequencer
  import ub_read_sequencer_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14,
  parameter int TILE_WIDTH   = UB_TILE_WIDTH,
  parameter int READ_LATENCY = UB_READ_LATENCY,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  BUFFER_ADDRESS_TYPE            cmd_base_addr,
  input  logic [15:0]                   cmd_rows,
  input  logic [7:0]                    cmd_stride,
  output BUFFER_ADDRESS_TYPE            ub_address0,
  output logic                          ub_en0,
  input  BYTE_TYPE [0:MATRIX_WIDTH-1]   ub_read_port0,
  output logic                          out_valid,
  input  logic                          out_ready,
  output BYTE_TYPE [0:MATRIX_WIDTH-1]   out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int DW = 8 * MATRIX_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $bits(BUFFER_ADDRESS_TYPE);
  localparam int RL = READ_LATENCY;

  ub_rd_state_t       state_q, state_d;
  BUFFER_ADDRESS_TYPE cur_q, cur_d;
  BUFFER_ADDRESS_TYPE addr_q, addr_d;
  logic [7:0]         stride_q, stride_d;
  logic [15:0]        rem_q, rem_d;
  logic               en_q, en_d;
  logic               last_q, last_d;
  logic [RL-1:0]      sr_v_q, sr_v_d;
  logic [RL-1:0]      sr_l_q, sr_l_d;
  logic [CW-1:0]      infl_q, infl_d;

  logic [DW:0]        head;
  logic [CW-1:0]      count;
  logic               push, pop, credit;
  logic [CW:0]        occ;
  logic [AW:0]        sum;

  ub_return_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({sr_l_q[RL-1], ub_read_port0}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign push      = sr_v_q[RL-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid && head[DW];
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE) || (cmd_valid && cmd_ready);
  assign ub_en0    = en_q;
  assign ub_address0 = addr_q;

  // Occupancy counts reads in flight plus rows queued, net of this pop.
  assign occ    = (CW+1)'(infl_q) + (CW+1)'(count) - (CW+1)'(pop);
  assign credit = occ < (CW+1)'(FIFO_DEPTH);
  assign sum    = {1'b0, cur_q} + (AW+1)'(stride_q);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    en_d     = 1'b0;
    last_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_d    = cmd_base_addr;
          stride_d = cmd_stride;
          rem_d    = cmd_rows;
          state_d  = (cmd_rows != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (credit) begin
          en_d   = 1'b1;
          last_d = (rem_q == 16'd1);
          addr_d = cur_q;
          cur_d  = (sum >= (AW+1)'(TILE_WIDTH)) ?
                   AW'(sum - (AW+1)'(TILE_WIDTH)) : AW'(sum);
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_q == '0 &&
            (count == '0 || (count == CW'(1) && pop)))
          state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sr_v_d = (sr_v_q << 1) | RL'(en_q);
    sr_l_d = (sr_l_q << 1) | RL'(last_q);
    infl_d = infl_q + CW'(en_d) - CW'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      en_q     <= 1'b0;
      last_q   <= 1'b0;
      sr_v_q   <= '0;
      sr_l_q   <= '0;
      infl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      en_q     <= en_d;
      last_q   <= last_d;
      sr_v_q   <= sr_v_d;
      sr_l_q   <= sr_l_d;
      infl_q   <= infl_d;
    end
  end

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Scoreboard bench for ub_read_sequencer with a latency-3 buffer model.
module tb_ub_read_sequencer;
  import ub_read_sequencer_pkg::*;

  localparam int MW = 14;
  localparam int TW = 4096;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  BUFFER_ADDRESS_TYPE cmd_base_addr;
  logic [15:0]        cmd_rows;
  logic [7:0]         cmd_stride;
  BUFFER_ADDRESS_TYPE ub_address0;
  logic               ub_en0;
  BYTE_TYPE [0:MW-1]  ub_read_port0;
  logic               out_valid;
  logic               out_ready;
  BYTE_TYPE [0:MW-1]  out_data;
  logic               out_last;
  logic               busy;

  int tests = 0;
  int fails = 0;
  int rmode = 1;
  logic acc_busy;

  logic [8*MW-1:0] mem [TW];
  logic [8*MW-1:0] s1, s2, s3;
  logic [8*MW:0]   exp_q[$];
  int              exp_addr_q[$];

  always #5 clk = ~clk;

  ub_read_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_rows      (cmd_rows),
    .cmd_stride    (cmd_stride),
    .ub_address0   (ub_address0),
    .ub_en0        (ub_en0),
    .ub_read_port0 (ub_read_port0),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy)
  );

  // Unified buffer: RAM register plus two output registers.
  always @(posedge clk) begin
    if (ub_en0) s1 <= mem[ub_address0];
    s2 <= s1;
    s3 <= s2;
  end
  assign ub_read_port0 = s3;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    end
  end

  logic          stall_q = 1'b0;
  logic [8*MW:0] stall_v;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (ub_en0) begin
        if (exp_addr_q.size() == 0) fail_now("addr_unexpected");
        else chk("addr", 128'(ub_address0), 128'(exp_addr_q.pop_front()));
      end
      if (stall_q)
        chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, stall_v});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("row_unexpected");
        else chk("row", {out_last, out_data}, exp_q.pop_front());
      end
      stall_q = out_valid && !out_ready;
      stall_v = {out_last, out_data};
    end
  end

  task automatic send_cmd(input int base, input int rows, input int stride);
    int n = 0;
    int a;
    @(posedge clk);
    #1;
    cmd_valid     = 1'b1;
    cmd_base_addr = 12'(base);
    cmd_rows      = 16'(rows);
    cmd_stride    = 8'(stride);
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    acc_busy = busy;
    for (int i = 0; i < rows; i++) begin
      a = (base + i * stride) % TW;
      exp_addr_q.push_back(a);
      exp_q.push_back({i == rows - 1, mem[a]});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((busy || out_valid) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) fail_now({nm, "_timeout"});
    chk({nm, "_drained"}, 128'(exp_q.size() + exp_addr_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    BYTE_TYPE [0:MW-1] r;
    int fe, le, ne, fv, nb, nv;

    for (int a = 0; a < TW; a++) begin
      for (int b = 0; b < MW; b++) r[b] = 8'($urandom);
      mem[a] = r;
    end
    for (int b = 0; b < MW; b++) r[b] = 8'(8'h7F - b);
    mem[0] = r;
    for (int b = 0; b < MW; b++) r[b] = 8'(8'h71 - b);
    mem[1] = r;
    mem[2] = '0;
    mem[3] = '0;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_base_addr = '0;
    cmd_rows = '0;
    cmd_stride = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {cmd_ready, ub_en0, ub_address0, out_valid,
                      out_data, out_last, busy},
        {1'b1, 1'b0, 12'd0, 1'b0, 112'd0, 1'b0, 1'b0});

    // 1: basic four-row read, latency and known data
    send_cmd(0, 4, 1);
    fe = -1; le = -1; ne = 0; fv = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ub_en0) begin
        if (fe < 0) fe = c;
        le = c;
        ne++;
      end
      if (out_valid && fv < 0) begin
        fv = c;
        chk("t1_row0_b0", out_data[0], 8'h7F);
        chk("t1_row0_b13", out_data[MW-1], 8'h72);
      end
    end
    chk("t1_en_count", ne, 4);
    chk("t1_en_consec", 128'(le - fe), 3);
    chk("t1_latency", 128'(fv - fe), 4);
    wait_idle("t1");

    // 2: backpressure limits issue to FIFO depth
    rmode = 0;
    repeat (3) @(posedge clk);
    send_cmd(100, 8, 1);
    ne = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ub_en0) ne++;
    end
    chk("t2_en_stalled", ne, 4);
    chk("t2_en_low", ub_en0, 0);
    rmode = 1;
    wait_idle("t2");

    // 3: address wrap
    send_cmd(4094, 4, 1);
    wait_idle("t3");

    // 4: zero-row command
    send_cmd(0, 0, 5);
    nb = acc_busy ? 1 : 0;
    ne = 0; nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ub_en0) ne++;
      if (out_valid) nv++;
    end
    chk("t4_busy_cycles", nb, 2);
    chk("t4_no_en", ne, 0);
    chk("t4_no_valid", nv, 0);
    send_cmd(7, 3, 2);
    wait_idle("t4b");

    // 5: reset with reads in flight
    send_cmd(200, 8, 1);
    ne = 0;
    for (int c = 0; c < 20 && ne < 2; c++) begin
      @(negedge clk);
      if (ub_en0) ne++;
    end
    chk("t5_two_issued", ne, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    chk("t5_rst_cmd_ready", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nv = 0; ne = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
      if (ub_en0) ne++;
    end
    chk("t5_no_valid", nv, 0);
    chk("t5_no_en", ne, 0);
    send_cmd(0, 4, 1);
    wait_idle("t5b");

    // 6: random backpressure, stride 3
    rmode = 2;
    send_cmd(int'($urandom_range(0, TW - 1)), 16, 3);
    wait_idle("t6");

    // random commands
    for (int k = 0; k < 25; k++) begin
      rmode = ($urandom_range(0, 2) == 0) ? 1 : 2;
      send_cmd(int'($urandom_range(0, TW - 1)),
               int'($urandom_range(0, 20)),
               int'($urandom_range(0, 255)));
      wait_idle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
